// File: rtl/cache_axi_responder_if.sv
// Request/response bundle between a cache controller and its backing-line responder.
// The master side drives the request; the slave side returns ready, rdata, the error flag and the count.
interface cache_axi_responder_if;
    logic         i_cache_rw_axi_valid;
    logic         i_cache_rw_axi_op;
    logic [511:0] i_cache_rw_axi_wdata;
    logic [63:0]  i_cache_rw_axi_addr;
    logic [1:0]   i_cache_rw_axi_size;
    logic [7:0]   i_cache_rw_axi_blks;
    logic         o_cache_rw_axi_ready;
    logic [511:0] o_cache_rw_axi_rdata;
    logic         o_err;
    logic [31:0]  o_txn_cnt;

    modport master (
        output i_cache_rw_axi_valid, i_cache_rw_axi_op, i_cache_rw_axi_wdata,
               i_cache_rw_axi_addr, i_cache_rw_axi_size, i_cache_rw_axi_blks,
        input  o_cache_rw_axi_ready, o_cache_rw_axi_rdata, o_err, o_txn_cnt
    );

    modport slave (
        input  i_cache_rw_axi_valid, i_cache_rw_axi_op, i_cache_rw_axi_wdata,
               i_cache_rw_axi_addr, i_cache_rw_axi_size, i_cache_rw_axi_blks,
        output o_cache_rw_axi_ready, o_cache_rw_axi_rdata, o_err, o_txn_cnt
    );
endinterface

// File: rtl/cache_axi_responder.sv
// Fixed-latency single-line memory responder: one request in flight, completes with a one-cycle
// ready pulse; out-of-range or malformed requests complete with o_err and leave memory untouched.
module cache_axi_responder #(
    parameter int          LATENCY     = 4,
    parameter int          DEPTH_LINES = 16,
    parameter logic [63:0] BASE_ADDR   = 64'h8000_0000
) (
    input logic                  clk,
    input logic                  rst,
    cache_axi_responder_if.slave bus
);
    localparam int          IDX_W = (DEPTH_LINES > 1) ? $clog2(DEPTH_LINES) : 1;
    localparam logic [63:0] SPAN  = 64'(DEPTH_LINES) * 64'd64;
    localparam logic [7:0]  CNT_LOAD = 8'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP, WAIT} state_t;

    state_t state, state_nxt;
    logic [7:0] cnt, cnt_nxt;

    logic         op_q;
    logic [63:0]  addr_q;
    logic [511:0] wdata_q;
    logic [1:0]   size_q;
    logic [7:0]   blks_q;

    logic [DEPTH_LINES-1:0][7:0][63:0] mem;
    logic [511:0] rdata_q;
    logic         err_q;
    logic [31:0]  txn_q;

    // In IDLE the live inputs are the request, so LATENCY=1 can commit on the acceptance edge.
    logic         req_op;
    logic [63:0]  req_addr;
    logic [511:0] req_wdata;
    logic [1:0]   req_size;
    logic [7:0]   req_blks;
    logic [63:0]  offs;
    logic         req_err;
    logic [IDX_W-1:0] idx;
    logic         commit;

    always_comb begin
        if (state == IDLE) begin
            req_op    = bus.i_cache_rw_axi_op;
            req_addr  = bus.i_cache_rw_axi_addr;
            req_wdata = bus.i_cache_rw_axi_wdata;
            req_size  = bus.i_cache_rw_axi_size;
            req_blks  = bus.i_cache_rw_axi_blks;
        end else begin
            req_op    = op_q;
            req_addr  = addr_q;
            req_wdata = wdata_q;
            req_size  = size_q;
            req_blks  = blks_q;
        end
        offs    = req_addr - BASE_ADDR;
        req_err = (req_addr < BASE_ADDR) || (offs >= SPAN) ||
                  (req_size != 2'b11) || (req_blks != 8'd0);
        idx     = offs[6 +: IDX_W];
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: if (bus.i_cache_rw_axi_valid) begin
                if (LATENCY == 1) begin
                    state_nxt = RESP;
                end else begin
                    state_nxt = BUSY;
                    cnt_nxt   = CNT_LOAD;
                end
            end
            BUSY: if (cnt <= 8'd1) state_nxt = RESP;
                  else             cnt_nxt   = cnt - 8'd1;
            RESP: state_nxt = bus.i_cache_rw_axi_valid ? WAIT : IDLE;
            // A request still held after its ready pulse must not be taken a second time.
            WAIT: if (!bus.i_cache_rw_axi_valid) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign commit = (state_nxt == RESP);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= 8'd0;
            op_q    <= 1'b0;
            addr_q  <= 64'd0;
            wdata_q <= 512'd0;
            size_q  <= 2'd0;
            blks_q  <= 8'd0;
            rdata_q <= 512'd0;
            err_q   <= 1'b0;
            txn_q   <= 32'd0;
            for (int i = 0; i < DEPTH_LINES; i++)
                for (int j = 0; j < 8; j++)
                    mem[i][j] <= 64'h01234567_00000000 |
                                 (BASE_ADDR + 64'(i) * 64'd64 + 64'(j) * 64'd8);
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (state == IDLE && bus.i_cache_rw_axi_valid) begin
                op_q    <= bus.i_cache_rw_axi_op;
                addr_q  <= bus.i_cache_rw_axi_addr;
                wdata_q <= bus.i_cache_rw_axi_wdata;
                size_q  <= bus.i_cache_rw_axi_size;
                blks_q  <= bus.i_cache_rw_axi_blks;
            end
            err_q <= commit && req_err;
            if (commit) begin
                txn_q <= txn_q + 32'd1;
                if (req_err)     rdata_q  <= 512'd0;
                else if (req_op) mem[idx] <= req_wdata;
                else             rdata_q  <= mem[idx];
            end
        end
    end

    assign bus.o_cache_rw_axi_ready = (state == RESP);
    assign bus.o_cache_rw_axi_rdata = rdata_q;
    assign bus.o_err                = err_q;
    assign bus.o_txn_cnt            = txn_q;
endmodule

// File: tb/tb_cache_axi_responder.sv
// Bench for cache_axi_responder: two instances (LATENCY 4 and 1) checked against a line-array model.
module tb_cache_axi_responder;
    localparam logic [63:0] BASE  = 64'h8000_0000;
    localparam int          LINES = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    cache_axi_responder_if if0();
    cache_axi_responder_if if1();

    cache_axi_responder #(.LATENCY(4), .DEPTH_LINES(LINES), .BASE_ADDR(BASE))
        dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
    cache_axi_responder #(.LATENCY(1), .DEPTH_LINES(LINES), .BASE_ADDR(BASE))
        dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

    int total = 0;
    int bad   = 0;

    logic [511:0] mm [2][LINES];
    logic [511:0] m_rdata [2];
    logic [31:0]  m_cnt [2];

    function automatic logic [63:0] rst_word(int i, int j);
        return 64'h01234567_00000000 | (BASE + 64'(i) * 64 + 64'(j) * 8);
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < LINES; i++)
                for (int j = 0; j < 8; j++)
                    mm[s][i][j*64 +: 64] = rst_word(i, j);
            m_rdata[s] = '0;
            m_cnt[s]   = '0;
        end
    endtask

    function automatic logic o_rdy(bit s);
        return s ? if1.o_cache_rw_axi_ready : if0.o_cache_rw_axi_ready;
    endfunction
    function automatic logic o_err(bit s);
        return s ? if1.o_err : if0.o_err;
    endfunction
    function automatic logic [511:0] o_rdata(bit s);
        return s ? if1.o_cache_rw_axi_rdata : if0.o_cache_rw_axi_rdata;
    endfunction
    function automatic logic [31:0] o_cnt(bit s);
        return s ? if1.o_txn_cnt : if0.o_txn_cnt;
    endfunction

    task automatic check(string tag, logic [511:0] obs, logic [511:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic set_valid(bit s, logic v);
        if (s) if1.i_cache_rw_axi_valid = v;
        else   if0.i_cache_rw_axi_valid = v;
    endtask

    task automatic set_req(logic op, logic [63:0] addr, logic [511:0] wd,
                           logic [1:0] size, logic [7:0] blks);
        if0.i_cache_rw_axi_op = op;     if1.i_cache_rw_axi_op = op;
        if0.i_cache_rw_axi_addr = addr; if1.i_cache_rw_axi_addr = addr;
        if0.i_cache_rw_axi_wdata = wd;  if1.i_cache_rw_axi_wdata = wd;
        if0.i_cache_rw_axi_size = size; if1.i_cache_rw_axi_size = size;
        if0.i_cache_rw_axi_blks = blks; if1.i_cache_rw_axi_blks = blks;
    endtask

    function automatic logic [511:0] rand_line();
        logic [511:0] v;
        for (int w = 0; w < 16; w++) v[w*32 +: 32] = $urandom;
        return v;
    endfunction

    // One full transaction; hold>0 keeps valid high for that many cycles after the ready pulse.
    task automatic txn(bit s, logic op, logic [63:0] addr, logic [511:0] wd,
                       logic [1:0] size, logic [7:0] blks, int hold);
        int  lat;
        bit  e;
        int  idx;
        lat = s ? 1 : 4;
        @(negedge clk);
        set_req(op, addr, wd, size, blks);
        set_valid(s, 1'b1);
        @(posedge clk);
        #1;
        if (hold == 0) begin
            set_valid(s, 1'b0);
            set_req(~op, 64'($urandom), rand_line(), 2'($urandom), 8'($urandom));
        end
        e = (addr < BASE) || (addr >= BASE + 64'(LINES * 64)) || (size != 2'b11) || (blks != 8'd0);
        idx = e ? 0 : int'((addr - BASE) >> 6);
        if (e)       m_rdata[s] = '0;
        else if (op) mm[s][idx] = wd;
        else         m_rdata[s] = mm[s][idx];
        m_cnt[s]++;
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            if (k < lat) begin
                check("busy_ready", o_rdy(s), 1'b0);
                check("busy_err", o_err(s), 1'b0);
            end else begin
                check("resp_ready", o_rdy(s), 1'b1);
                check("resp_err", o_err(s), e);
                check("resp_rdata", o_rdata(s), m_rdata[s]);
                check("resp_cnt", o_cnt(s), m_cnt[s]);
            end
        end
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check("hold_ready", o_rdy(s), 1'b0);
            check("hold_err", o_err(s), 1'b0);
        end
        if (hold > 0) set_valid(s, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [511:0] a5;
        logic [511:0] t;
        bit s;
        a5 = {64{8'hA5}};
        set_valid(0, 1'b0);
        set_valid(1, 1'b0);
        set_req(1'b0, '0, '0, 2'b11, 8'd0);
        model_reset();
        #12;
        for (int d = 0; d < 2; d++) begin
            check("rst_ready", o_rdy(d[0]), 1'b0);
            check("rst_err", o_err(d[0]), 1'b0);
            check("rst_rdata", o_rdata(d[0]), '0);
            check("rst_cnt", o_cnt(d[0]), '0);
        end
        @(negedge clk);
        rst = 1'b1;

        // Reset-pattern read
        txn(0, 1'b0, BASE + 64'h40, '0, 2'b11, 8'd0, 0);
        t = o_rdata(0);
        check("r035_word0", t[63:0], 64'h01234567_80000040);
        check("r035_word7", t[511:448], 64'h01234567_80000078);
        check("r035_cnt", o_cnt(0), 32'd1);

        // Write then read back with ignored low address bits
        txn(0, 1'b1, BASE + 64'h80, a5, 2'b11, 8'd0, 0);
        txn(0, 1'b0, BASE + 64'hBF, '0, 2'b11, 8'd0, 0);
        check("r036_a5", o_rdata(0), a5);

        // Error requests leave memory alone
        txn(0, 1'b0, BASE + 64'h400, '0, 2'b11, 8'd0, 0);
        txn(0, 1'b0, BASE, '0, 2'b11, 8'd1, 0);
        txn(0, 1'b1, BASE + 64'h80, rand_line(), 2'b10, 8'd0, 0);
        txn(0, 1'b1, BASE - 64'h40, rand_line(), 2'b11, 8'd0, 0);
        txn(0, 1'b0, BASE + 64'h80, '0, 2'b11, 8'd0, 0);
        txn(0, 1'b0, BASE + 64'h3FF, '0, 2'b11, 8'd0, 0);

        // Held valid: one pulse only, then a normal request
        txn(0, 1'b0, BASE + 64'h100, '0, 2'b11, 8'd0, 5);
        txn(0, 1'b1, BASE + 64'h100, rand_line(), 2'b11, 8'd0, 0);

        // Reset in the second BUSY cycle aborts the write
        @(negedge clk);
        set_req(1'b1, BASE + 64'hC0, a5, 2'b11, 8'd0);
        set_valid(0, 1'b1);
        @(posedge clk);
        #1 set_valid(0, 1'b0);
        @(negedge clk);
        check("abort_busy1", o_rdy(0), 1'b0);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        model_reset();
        check("abort_ready", o_rdy(0), 1'b0);
        check("abort_cnt", o_cnt(0), 32'd0);
        check("abort_rdata", o_rdata(0), '0);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("abort_no_ready", o_rdy(0), 1'b0);
        end
        check("abort_cnt_after", o_cnt(0), 32'd0);
        txn(0, 1'b0, BASE + 64'hC0, '0, 2'b11, 8'd0, 0);

        // LATENCY=1 back-to-back
        txn(1, 1'b0, BASE + 64'h140, '0, 2'b11, 8'd0, 0);
        txn(1, 1'b1, BASE + 64'h140, a5, 2'b11, 8'd0, 0);
        txn(1, 1'b0, BASE + 64'h140, '0, 2'b11, 8'd0, 0);
        check("r040_cnt", o_cnt(1), 32'd3);
        check("r040_rdata", o_rdata(1), a5);
        txn(1, 1'b0, BASE + 64'h140, '0, 2'b11, 8'd0, 2);

        // Randomized traffic on both instances
        for (int n = 0; n < 60; n++) begin
            logic [63:0] addr;
            logic [1:0]  size;
            logic [7:0]  blks;
            s = 1'($urandom);
            if ($urandom_range(0, 9) == 0) addr = BASE - 64'($urandom_range(1, 256));
            else                           addr = BASE + 64'($urandom_range(0, LINES * 64 + 127));
            size = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
            blks = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
            txn(s, 1'($urandom), addr, rand_line(), size, blks, ($urandom_range(0, 5) == 0) ? 2 : 0);
        end

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cache_axi_responder.md
CACHE_AXI_RESPONDER -- requirements
Module: cache_axi_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 4, meaning cycles from request acceptance to the ready pulse (legal range 1..255).
REQ-002 SHALL have parameter DEPTH_LINES, default 16, meaning the number of 512-bit lines stored (power of two).
REQ-003 SHALL have parameter BASE_ADDR, default 64'h8000_0000, meaning the byte address of line 0.
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port clk, input, 1, the clock.
REQ-006 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port i_cache_rw_axi_valid, input, 1, request valid.
REQ-008 SHALL have port i_cache_rw_axi_op, input, 1, 0 = read, 1 = write.
REQ-009 SHALL have port i_cache_rw_axi_wdata, input, 512, write line.
REQ-010 SHALL have port i_cache_rw_axi_addr, input, 64, byte address; bits [5:0] are ignored.
REQ-011 SHALL have port i_cache_rw_axi_size, input, 2, beat size; 2'b11 (64-bit) is the only legal value.
REQ-012 SHALL have port i_cache_rw_axi_blks, input, 8, extra lines; 0 is the only legal value.
REQ-013 SHALL have port o_cache_rw_axi_ready, output, 1, one-cycle completion pulse.
REQ-014 SHALL have port o_cache_rw_axi_rdata, output, 512, read line.
REQ-015 SHALL have port o_err, output, 1, error flag accompanying ready.
REQ-016 SHALL have port o_txn_cnt, output, 32, count of completed transactions.

Function
REQ-017 SHALL implement the FSM states IDLE, BUSY, RESP and WAIT.
REQ-018 In IDLE, a clock edge with valid=1 SHALL capture op, addr, wdata, size and blks, load the latency counter, and move to BUSY.
REQ-019 BUSY SHALL count LATENCY-1 cycles, so ready is high exactly in the cycle LATENCY cycles after the acceptance edge; LATENCY=1 goes directly to RESP.
REQ-020 RESP SHALL last exactly one cycle with ready=1; the next state is IDLE if valid=0, otherwise WAIT.
REQ-021 WAIT SHALL hold ready=0 until valid is sampled 0, then move to IDLE, so one held request is never accepted twice.
REQ-022 Once captured, the request SHALL be unaffected by valid or any input changing during BUSY (valid dropping is a protocol violation; the request completes anyway).
REQ-023 A request SHALL be in range when BASE_ADDR <= addr < BASE_ADDR + DEPTH_LINES*64; its line index is (addr - BASE_ADDR) >> 6.
REQ-024 An error request SHALL be one that is out of range, has size != 2'b11, or has blks != 0.
REQ-025 For an error request: ready still pulses, o_err=1 for that cycle only, rdata=0, and memory is unchanged.
REQ-026 A legal write SHALL commit wdata to its line on the edge entering RESP; rdata is unchanged.
REQ-027 A legal read SHALL load rdata from the memory contents on the edge entering RESP.
REQ-028 rdata SHALL hold its value until the next completed read or error.
REQ-029 o_err SHALL be 0 in every cycle other than a RESP error cycle.
REQ-030 o_txn_cnt SHALL increment by 1 on every RESP cycle, including errors, and wrap from 32'hFFFF_FFFF to 0.

Reset
REQ-031 On rst=0 (asynchronous): state=IDLE, ready=0, rdata=0, o_err=0, o_txn_cnt=0.
REQ-032 On rst=0, every 64-bit word j of line i SHALL be set to 64'h01234567_00000000 | (BASE_ADDR + i*64 + j*8).
REQ-033 Reset asserted during BUSY SHALL abort the request: no write is committed and no ready pulse occurs.
REQ-034 After rst returns to 1, the first edge with valid=1 SHALL be accepted normally.

Verification
REQ-035 Read at addr 64'h8000_0040, LATENCY=4 -> ready high for 1 cycle, 4 cycles after acceptance; rdata word0 = 64'h01234567_80000040, word7 = 64'h01234567_80000078; o_err=0; o_txn_cnt=1.
REQ-036 Write line 64'h8000_0080 with 512'hA5 repeated, then read 64'h8000_00BF -> read returns the A5 pattern (low bits ignored); o_txn_cnt=2.
REQ-037 Read at 64'h8000_0400 (DEPTH_LINES=16, out of range), and separately blks=1 -> each gives ready pulse with o_err=1 and rdata=0; memory unchanged.
REQ-038 Valid held high for 5 cycles after ready -> exactly one ready pulse; the next request is accepted only after valid is sampled 0.
REQ-039 Write issued, rst pulsed low in the 2nd BUSY cycle -> no ready pulse; a subsequent read returns the reset pattern; o_txn_cnt=0.
REQ-040 LATENCY=1 back-to-back read/write/read with valid dropped one cycle between each -> each ready occurs 1 cycle after acceptance; o_txn_cnt=3.
